// File: rtl/sr_axi_burst_bridge_pkg.sv
// Shared types and AXI encodings for the core-to-AXI burst bridge.
//   state_t        : bridge FSM states
//   AXI_RESP_*     : xRESP encodings
//   AXI_BURST_INCR : AxBURST encoding for incrementing bursts
package sr_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WB,
      AR,
      RD,
      RSP
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/sr_axi_burst_bridge_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) used by the burst bridge.
//   m : master side (drives valids/addresses/write data, RREADY/BREADY)
//   s : slave side (drives readies, B and R responses)
interface axi_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int ID_W   = 4
);

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [ID_W-1:0]       awid;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;

   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;

   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     araddr;
   logic [ID_W-1:0]       arid;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;

   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;
   logic                  rlast;

   modport m (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rlast,
      output rready
   );

   modport s (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rresp, rlast,
      input  rready
   );

endinterface

// File: rtl/sr_axi_burst_bridge.sv
// Core req/resp port to AXI4 master bridge, one transaction outstanding.
// A CORE_DW word is carried as an INCR burst of CORE_DW/AXI_DW beats.
//   clk, rst_n        : clock, asynchronous active-low reset
//   mem_req_*         : core request (valid/ready, wr, addr, wdata, be)
//   mem_resp_*        : core response (valid/ready, rdata, err), held until accepted
//   m_axi             : AXI4 master bundle
module sr_axi_burst_bridge
   import sr_axi_bridge_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int CORE_DW  = 32,
   parameter int AXI_DW   = 8,
   parameter int ID_W     = 4,
   parameter int ID_SHIFT = 12,
   parameter int ID_BASE  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_req_valid_i,
   output logic                 mem_req_ready_o,
   input  logic                 mem_wr_i,
   input  logic [ADDR_W-1:0]    mem_addr_i,
   input  logic [CORE_DW-1:0]   mem_wdata_i,
   input  logic [CORE_DW/8-1:0] mem_be_i,
   output logic                 mem_resp_valid_o,
   input  logic                 mem_resp_ready_i,
   output logic [CORE_DW-1:0]   mem_rdata_o,
   output logic                 mem_resp_err_o,
   axi_if.m                     m_axi
);

   localparam int BEATS  = CORE_DW / AXI_DW;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int STRB_W = AXI_DW / 8;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   state_t                r_state;
   state_t                w_next;

   logic                  r_wr;
   logic [ADDR_W-1:0]     r_addr;
   logic [CORE_DW-1:0]    r_wdata;
   logic [CORE_DW/8-1:0]  r_be;
   logic [CORE_DW-1:0]    r_rdata;
   logic                  r_err;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic [BEAT_W-1:0]     r_wbeat;
   logic [BEAT_W-1:0]     r_rbeat;

   logic                  w_req_hs;
   logic                  w_awvalid;
   logic                  w_wvalid;
   logic                  w_wlast;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_r_hs;

   // All AXI valids/readies decode from registered state only.
   assign w_req_hs  = (r_state == IDLE) && mem_req_valid_i;
   assign w_awvalid = (r_state == WR) && !r_aw_done;
   assign w_wvalid  = (r_state == WR) && !r_w_done;
   assign w_wlast   = (r_wbeat == LAST_BEAT);
   assign w_aw_hs   = w_awvalid && m_axi.awready;
   assign w_w_hs    = w_wvalid && m_axi.wready;
   assign w_r_hs    = (r_state == RD) && m_axi.rvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_req_hs) w_next = mem_wr_i ? WR : AR;
         // AW and the W stream complete independently; the exit may see
         // both final handshakes in the same cycle.
         WR:   if ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && w_wlast))) w_next = WB;
         WB:   if (m_axi.bvalid) w_next = RSP;
         AR:   if (m_axi.arready) w_next = RD;
         RD:   if (w_r_hs && m_axi.rlast) w_next = RSP;
         RSP:  if (mem_resp_ready_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_wbeat   <= '0;
         r_rbeat   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_hs) begin
                  r_wr      <= mem_wr_i;
                  r_addr    <= mem_addr_i;
                  r_wdata   <= mem_wdata_i;
                  r_be      <= mem_be_i;
                  r_err     <= 1'b0;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_wbeat   <= '0;
                  r_rbeat   <= '0;
               end
            end
            WR: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs) begin
                  if (w_wlast) r_w_done <= 1'b1;
                  else         r_wbeat  <= r_wbeat + BEAT_W'(1);
               end
            end
            WB: begin
               if (m_axi.bvalid && (m_axi.bresp != AXI_RESP_OKAY)) r_err <= 1'b1;
            end
            RD: begin
               if (w_r_hs) begin
                  r_rdata[r_rbeat*AXI_DW +: AXI_DW] <= m_axi.rdata;
                  // A burst ending on any beat other than the last index is
                  // reported as an error; extra beats overwrite the top slot.
                  if ((m_axi.rresp != AXI_RESP_OKAY) ||
                      (m_axi.rlast && (r_rbeat != LAST_BEAT))) r_err <= 1'b1;
                  if (!m_axi.rlast && (r_rbeat != LAST_BEAT)) r_rbeat <= r_rbeat + BEAT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_ready_o  = (r_state == IDLE);
   assign mem_resp_valid_o = (r_state == RSP);
   assign mem_rdata_o      = r_rdata;
   assign mem_resp_err_o   = r_err;

   assign m_axi.awvalid = w_awvalid;
   assign m_axi.awaddr  = r_addr;
   assign m_axi.awid    = ID_W'((r_addr >> ID_SHIFT) + ADDR_W'(ID_BASE));
   assign m_axi.awlen   = 8'(BEATS - 1);
   assign m_axi.awsize  = 3'($clog2(STRB_W));
   assign m_axi.awburst = AXI_BURST_INCR;

   assign m_axi.wvalid  = w_wvalid;
   assign m_axi.wdata   = r_wdata[r_wbeat*AXI_DW +: AXI_DW];
   assign m_axi.wstrb   = r_be[r_wbeat*STRB_W +: STRB_W];
   assign m_axi.wlast   = w_wlast;

   assign m_axi.bready  = (r_state == WB);

   assign m_axi.arvalid = (r_state == AR);
   assign m_axi.araddr  = r_addr;
   assign m_axi.arid    = ID_W'((r_addr >> ID_SHIFT) + ADDR_W'(ID_BASE));
   assign m_axi.arlen   = 8'(BEATS - 1);
   assign m_axi.arsize  = 3'($clog2(STRB_W));
   assign m_axi.arburst = AXI_BURST_INCR;

   assign m_axi.rready  = (r_state == RD);

   // r_wr is kept for debug visibility of the latched direction.
   logic w_unused;
   assign w_unused = r_wr;

endmodule

// File: tb/tb_sr_axi_burst_bridge.sv
module tb_sr_axi_burst_bridge;
   import sr_axi_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // 32/8 instance
   logic        req_valid = 0, req_ready, wr = 0;
   logic [15:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        resp_valid, resp_ready = 0, resp_err;
   logic [31:0] rdata;

   axi_if #(.ADDR_W(16), .DATA_W(8), .ID_W(4)) ax ();

   sr_axi_burst_bridge #(
      .ADDR_W(16), .CORE_DW(32), .AXI_DW(8), .ID_W(4), .ID_SHIFT(12), .ID_BASE(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req_valid_i(req_valid), .mem_req_ready_o(req_ready),
      .mem_wr_i(wr), .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_be_i(be),
      .mem_resp_valid_o(resp_valid), .mem_resp_ready_i(resp_ready),
      .mem_rdata_o(rdata), .mem_resp_err_o(resp_err),
      .m_axi(ax)
   );

   // 64/32 instance
   logic        q_req_valid = 0, q_req_ready, q_wr = 0;
   logic [15:0] q_addr = '0;
   logic [63:0] q_wdata = '0;
   logic [7:0]  q_be = '0;
   logic        q_resp_valid, q_resp_ready = 0, q_resp_err;
   logic [63:0] q_rdata;

   axi_if #(.ADDR_W(16), .DATA_W(32), .ID_W(4)) ax64 ();

   sr_axi_burst_bridge #(
      .ADDR_W(16), .CORE_DW(64), .AXI_DW(32), .ID_W(4), .ID_SHIFT(12), .ID_BASE(1)
   ) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .mem_req_valid_i(q_req_valid), .mem_req_ready_o(q_req_ready),
      .mem_wr_i(q_wr), .mem_addr_i(q_addr), .mem_wdata_i(q_wdata), .mem_be_i(q_be),
      .mem_resp_valid_o(q_resp_valid), .mem_resp_ready_i(q_resp_ready),
      .mem_rdata_o(q_rdata), .mem_resp_err_o(q_resp_err),
      .m_axi(ax64)
   );

   // transaction capture for the 32/8 instance
   int          c_nw, c_naw, c_nb, c_nar, c_nr, c_last_cyc, c_resp_cyc;
   logic        c_got_resp, c_early_resp, c_err;
   logic [31:0] c_rdata;
   logic [7:0]  c_wdata [8];
   logic        c_wstrb [8];
   logic        c_wlast [8];
   logic [15:0] c_awaddr, c_araddr;
   logic [3:0]  c_awid, c_arid;
   logic [7:0]  c_awlen, c_arlen;
   logic [2:0]  c_awsize, c_arsize;
   logic [1:0]  c_awburst, c_arburst;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_slave();
      ax.awready = 0; ax.wready = 0; ax.bvalid = 0; ax.bresp = '0;
      ax.arready = 0; ax.rvalid = 0; ax.rdata = '0; ax.rresp = '0; ax.rlast = 0;
      ax64.awready = 0; ax64.wready = 0; ax64.bvalid = 0; ax64.bresp = '0;
      ax64.arready = 0; ax64.rvalid = 0; ax64.rdata = '0; ax64.rresp = '0; ax64.rlast = 0;
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
      req_valid = 1; wr = w; addr = a; wdata = d; be = b;
      tick();
      req_valid = 0;
   endtask

   task automatic accept_resp();
      resp_ready = 1;
      tick();
      resp_ready = 0;
   endtask

   // Read: AR accepted at once, beats 0..last_beat with RLAST on last_beat,
   // SLVERR on err_beat; returns when the response appears or the budget ends.
   task automatic rd_txn(input logic [15:0] a, input logic [31:0] d, input int err_beat, input int last_beat);
      int k;
      k = 0;
      c_nar = 0; c_nr = 0; c_got_resp = 0; c_last_cyc = -1; c_resp_cyc = -1;
      issue(1'b0, a, '0, '0);
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (resp_valid) begin
            c_got_resp = 1; c_resp_cyc = cyc; c_rdata = rdata; c_err = resp_err;
            break;
         end
         ax.arready = 1;
         ax.rvalid  = (k <= last_beat);
         ax.rdata   = (k < 4) ? d[k*8 +: 8] : 8'h00;
         ax.rlast   = (k == last_beat);
         ax.rresp   = (k == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         if (ax.arvalid && ax.arready) begin
            c_nar++;
            c_araddr = ax.araddr; c_arid = ax.arid; c_arlen = ax.arlen;
            c_arsize = ax.arsize; c_arburst = ax.arburst;
         end
         if (ax.rvalid && ax.rready) begin
            c_nr++;
            if (ax.rlast) c_last_cyc = cyc;
            k++;
         end
         tick();
      end
      clr_slave();
   endtask

   // Write: WREADY always high; AWREADY raised aw_delay cycles after the last
   // W beat (or at once when aw_delay is 0); one B after AW and all W.
   task automatic wr_txn(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b,
                         input int aw_delay, input logic [1:0] bresp_v);
      int dly;
      dly = 0;
      c_nw = 0; c_naw = 0; c_nb = 0; c_got_resp = 0; c_early_resp = 0;
      issue(1'b1, a, d, b);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (resp_valid) begin
            if (c_nb == 0) c_early_resp = 1;
            c_got_resp = 1; c_rdata = rdata; c_err = resp_err;
            break;
         end
         ax.wready  = 1;
         ax.awready = (aw_delay == 0) || ((c_nw >= 4) && (dly >= aw_delay));
         if (c_nw >= 4) dly++;
         ax.bvalid  = (c_naw > 0) && (c_nw >= 4) && (c_nb == 0);
         ax.bresp   = bresp_v;
         if (ax.awvalid && ax.awready) begin
            c_naw++;
            c_awaddr = ax.awaddr; c_awid = ax.awid; c_awlen = ax.awlen;
            c_awsize = ax.awsize; c_awburst = ax.awburst;
         end
         if (ax.wvalid && ax.wready) begin
            if (c_nw < 8) begin
               c_wdata[c_nw] = ax.wdata; c_wstrb[c_nw] = ax.wstrb[0]; c_wlast[c_nw] = ax.wlast;
            end
            c_nw++;
         end
         if (ax.bvalid && ax.bready) c_nb++;
         tick();
      end
      clr_slave();
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if ({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, resp_valid, resp_err} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outs: got %b want 0000000",
                  {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, resp_valid, resp_err});
      end
      n_vec++;
      if ({ax64.awvalid, ax64.wvalid, ax64.arvalid, ax64.bready, ax64.rready, q_resp_valid, q_resp_err} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outs64: got %b want 0000000",
                  {ax64.awvalid, ax64.wvalid, ax64.arvalid, ax64.bready, ax64.rready, q_resp_valid, q_resp_err});
      end
      tick();
      rst_n = 1;
      tick();
      n_vec++;
      if ({req_ready, q_req_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL reset_req_ready: got %b want 11", {req_ready, q_req_ready});
      end
   endtask

   task automatic test_read();
      rd_txn(16'h1234, 32'h44332211, -1, 3);
      n_vec++;
      if ({c_got_resp, c_nar, c_nr} !== {1'b1, 32'd1, 32'd4}) begin
         n_err++; $display("FAIL rd_counts: got resp=%0b ar=%0d r=%0d want 1/1/4", c_got_resp, c_nar, c_nr);
      end
      n_vec++;
      if ({c_araddr, c_arid, c_arlen, c_arsize, c_arburst} !== {16'h1234, 4'h2, 8'h03, 3'h0, 2'h1}) begin
         n_err++; $display("FAIL rd_ar_fields: got %h %h %h %h %h want 1234 2 03 0 1",
                           c_araddr, c_arid, c_arlen, c_arsize, c_arburst);
      end
      n_vec++;
      if ({c_rdata, c_err} !== {32'h44332211, 1'b0}) begin
         n_err++; $display("FAIL rd_data: got %h err=%0b want 44332211 err=0", c_rdata, c_err);
      end
      n_vec++;
      if (c_resp_cyc - c_last_cyc !== 1) begin
         n_err++; $display("FAIL rd_latency: got %0d want 1", c_resp_cyc - c_last_cyc);
      end
      accept_resp();
      n_vec++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_err++; $display("FAIL rd_to_idle: got %b want 01", {resp_valid, req_ready});
      end
   endtask

   task automatic test_write();
      wr_txn(16'h0040, 32'hDEADBEEF, 4'b0101, 0, AXI_RESP_OKAY);
      n_vec++;
      if ({c_got_resp, c_err, c_nb, c_nw} !== {1'b1, 1'b0, 32'd1, 32'd4}) begin
         n_err++; $display("FAIL wr_resp: got resp=%0b err=%0b b=%0d w=%0d want 1/0/1/4", c_got_resp, c_err, c_nb, c_nw);
      end
      n_vec++;
      if ({c_wdata[3], c_wdata[2], c_wdata[1], c_wdata[0]} !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL wr_wdata: got %h want deadbeef", {c_wdata[3], c_wdata[2], c_wdata[1], c_wdata[0]});
      end
      n_vec++;
      if ({c_wstrb[3], c_wstrb[2], c_wstrb[1], c_wstrb[0]} !== 4'b0101) begin
         n_err++; $display("FAIL wr_wstrb: got %b want 0101", {c_wstrb[3], c_wstrb[2], c_wstrb[1], c_wstrb[0]});
      end
      n_vec++;
      if ({c_wlast[3], c_wlast[2], c_wlast[1], c_wlast[0]} !== 4'b1000) begin
         n_err++; $display("FAIL wr_wlast: got %b want 1000", {c_wlast[3], c_wlast[2], c_wlast[1], c_wlast[0]});
      end
      n_vec++;
      if ({c_awaddr, c_awid, c_awlen, c_awsize, c_awburst} !== {16'h0040, 4'h1, 8'h03, 3'h0, 2'h1}) begin
         n_err++; $display("FAIL wr_aw_fields: got %h %h %h %h %h want 0040 1 03 0 1",
                           c_awaddr, c_awid, c_awlen, c_awsize, c_awburst);
      end
      accept_resp();
      // be=0 still bursts; ID (0xF+1) wraps to 0; SLVERR on B reported
      wr_txn(16'hF000, 32'h12345678, 4'b0000, 0, AXI_RESP_SLVERR);
      n_vec++;
      if ({c_wstrb[3], c_wstrb[2], c_wstrb[1], c_wstrb[0], c_nw} !== {4'b0000, 32'd4}) begin
         n_err++; $display("FAIL wr_be0: got strb=%b w=%0d want 0000/4", {c_wstrb[3], c_wstrb[2], c_wstrb[1], c_wstrb[0]}, c_nw);
      end
      n_vec++;
      if ({c_got_resp, c_err, c_awid} !== {1'b1, 1'b1, 4'h0}) begin
         n_err++; $display("FAIL wr_berr_id: got resp=%0b err=%0b id=%h want 1/1/0", c_got_resp, c_err, c_awid);
      end
      accept_resp();
   endtask

   task automatic test_aw_delay();
      int extra;
      extra = 0;
      wr_txn(16'h1000, 32'h01020304, 4'hF, 5, AXI_RESP_OKAY);
      n_vec++;
      if ({c_got_resp, c_early_resp, c_err} !== 3'b100) begin
         n_err++; $display("FAIL awdly_resp: got resp=%0b early=%0b err=%0b want 1/0/0", c_got_resp, c_early_resp, c_err);
      end
      n_vec++;
      if ({c_naw, c_nw, c_nb} !== {32'd1, 32'd4, 32'd1}) begin
         n_err++; $display("FAIL awdly_counts: got aw=%0d w=%0d b=%0d want 1/4/1", c_naw, c_nw, c_nb);
      end
      accept_resp();
      for (int i = 0; i < 4; i++) begin
         if (resp_valid) extra++;
         tick();
      end
      n_vec++;
      if (extra !== 0) begin
         n_err++; $display("FAIL awdly_single_resp: got %0d extra resp cycles want 0", extra);
      end
   endtask

   task automatic test_errors();
      rd_txn(16'h0100, 32'h0D0C0B0A, 2, 3);
      n_vec++;
      if ({c_got_resp, c_err, c_rdata} !== {1'b1, 1'b1, 32'h0D0C0B0A}) begin
         n_err++; $display("FAIL err_rresp: got resp=%0b err=%0b data=%h want 1/1/0d0c0b0a", c_got_resp, c_err, c_rdata);
      end
      accept_resp();
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL err_rresp_idle: got %0b want 1", req_ready);
      end
      rd_txn(16'h0200, 32'h44332211, -1, 1);
      n_vec++;
      if ({c_got_resp, c_err, c_nr} !== {1'b1, 1'b1, 32'd2}) begin
         n_err++; $display("FAIL err_early_rlast: got resp=%0b err=%0b r=%0d want 1/1/2", c_got_resp, c_err, c_nr);
      end
      n_vec++;
      if (c_rdata[15:0] !== 16'h2211) begin
         n_err++; $display("FAIL err_early_data: got %h want 2211", c_rdata[15:0]);
      end
      accept_resp();
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL err_early_idle: got %0b want 1", req_ready);
      end
   endtask

   task automatic test_back_to_back();
      rd_txn(16'h5000, 32'hCAFEF00D, -1, 3);
      n_vec++;
      if ({c_got_resp, c_err, c_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
         n_err++; $display("FAIL b2b_first: got resp=%0b err=%0b data=%h want 1/0/cafef00d", c_got_resp, c_err, c_rdata);
      end
      accept_resp();
      rd_txn(16'h6ABC, 32'h76543210, -1, 3);
      n_vec++;
      if ({c_got_resp, c_err, c_rdata, c_arid, c_araddr} !== {1'b1, 1'b0, 32'h76543210, 4'h7, 16'h6ABC}) begin
         n_err++; $display("FAIL b2b_second: got resp=%0b err=%0b data=%h id=%h addr=%h want 1/0/76543210/7/6abc",
                           c_got_resp, c_err, c_rdata, c_arid, c_araddr);
      end
      accept_resp();
   endtask

   task automatic test_resp_hold();
      rd_txn(16'h2000, 32'hA5A55A5A, -1, 3);
      req_valid = 1; wr = 0; addr = 16'h3000;
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if ({resp_valid, req_ready, rdata} !== {2'b10, 32'hA5A55A5A}) begin
            n_err++; $display("FAIL hold_cycle%0d: got valid=%0b rdy=%0b data=%h want 1/0/a5a55a5a",
                              i, resp_valid, req_ready, rdata);
         end
         tick();
      end
      req_valid = 0;
      accept_resp();
      tick();
      n_vec++;
      if ({ax.arvalid, req_ready} !== 2'b01) begin
         n_err++; $display("FAIL hold_no_req: got arvalid=%0b rdy=%0b want 0/1", ax.arvalid, req_ready);
      end
   endtask

   task automatic test_reset_mid_burst();
      issue(1'b1, 16'h0300, 32'h11223344, 4'hF);
      ax.wready = 1; ax.awready = 0;
      tick();
      tick();
      n_vec++;
      if ({ax.awvalid, ax.wvalid} !== 2'b11) begin
         n_err++; $display("FAIL rst_mid_active: got %b want 11", {ax.awvalid, ax.wvalid});
      end
      rst_n = 0;
      #1;
      n_vec++;
      if ({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, resp_valid, req_ready} !== 7'b0000001) begin
         n_err++; $display("FAIL rst_mid_outs: got %b want 0000001",
                           {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, resp_valid, req_ready});
      end
      clr_slave();
      tick();
      rst_n = 1;
      tick();
      rd_txn(16'h1234, 32'h99887766, -1, 3);
      n_vec++;
      if ({c_got_resp, c_err, c_rdata, c_arid} !== {1'b1, 1'b0, 32'h99887766, 4'h2}) begin
         n_err++; $display("FAIL rst_mid_recover: got resp=%0b err=%0b data=%h id=%h want 1/0/99887766/2",
                           c_got_resp, c_err, c_rdata, c_arid);
      end
      accept_resp();
   endtask

   task automatic test_param_sweep();
      q_req_valid = 1; q_wr = 1; q_addr = 16'h3008; q_wdata = 64'h0123456789ABCDEF; q_be = 8'hF3;
      tick();
      q_req_valid = 0;
      ax64.awready = 1; ax64.wready = 1;
      n_vec++;
      if ({ax64.awvalid, ax64.wvalid, ax64.awaddr, ax64.awid, ax64.awlen, ax64.awsize, ax64.awburst}
          !== {2'b11, 16'h3008, 4'h4, 8'h01, 3'h2, 2'h1}) begin
         n_err++; $display("FAIL p64_aw: got %b %h %h %h %h %h want 11 3008 4 01 2 1", {ax64.awvalid, ax64.wvalid},
                           ax64.awaddr, ax64.awid, ax64.awlen, ax64.awsize, ax64.awburst);
      end
      n_vec++;
      if ({ax64.wdata, ax64.wstrb, ax64.wlast} !== {32'h89ABCDEF, 4'h3, 1'b0}) begin
         n_err++; $display("FAIL p64_w0: got %h %h %0b want 89abcdef 3 0", ax64.wdata, ax64.wstrb, ax64.wlast);
      end
      tick();
      n_vec++;
      if ({ax64.awvalid, ax64.wvalid, ax64.wdata, ax64.wstrb, ax64.wlast} !== {2'b01, 32'h01234567, 4'hF, 1'b1}) begin
         n_err++; $display("FAIL p64_w1: got %b %h %h %0b want 01 01234567 f 1", {ax64.awvalid, ax64.wvalid},
                           ax64.wdata, ax64.wstrb, ax64.wlast);
      end
      tick();
      ax64.awready = 0; ax64.wready = 0;
      n_vec++;
      if ({ax64.bready, ax64.wvalid, ax64.awvalid} !== 3'b100) begin
         n_err++; $display("FAIL p64_wb: got %b want 100", {ax64.bready, ax64.wvalid, ax64.awvalid});
      end
      ax64.bvalid = 1; ax64.bresp = AXI_RESP_OKAY;
      tick();
      ax64.bvalid = 0;
      n_vec++;
      if ({q_resp_valid, q_resp_err} !== 2'b10) begin
         n_err++; $display("FAIL p64_wresp: got %b want 10", {q_resp_valid, q_resp_err});
      end
      q_resp_ready = 1;
      tick();
      q_resp_ready = 0;
      q_req_valid = 1; q_wr = 0; q_addr = 16'h0010;
      tick();
      q_req_valid = 0;
      n_vec++;
      if ({ax64.arvalid, ax64.arid, ax64.arlen, ax64.arsize} !== {1'b1, 4'h1, 8'h01, 3'h2}) begin
         n_err++; $display("FAIL p64_ar: got %0b %h %h %h want 1 1 01 2", ax64.arvalid, ax64.arid, ax64.arlen, ax64.arsize);
      end
      ax64.arready = 1;
      tick();
      ax64.arready = 0;
      ax64.rvalid = 1; ax64.rdata = 32'hDDCCBBAA; ax64.rlast = 0; ax64.rresp = AXI_RESP_OKAY;
      tick();
      ax64.rdata = 32'h44332211; ax64.rlast = 1;
      tick();
      ax64.rvalid = 0; ax64.rlast = 0;
      n_vec++;
      if ({q_resp_valid, q_resp_err, q_rdata} !== {2'b10, 64'h44332211DDCCBBAA}) begin
         n_err++; $display("FAIL p64_rd: got %b %h want 10 44332211ddccbbaa", {q_resp_valid, q_resp_err}, q_rdata);
      end
      q_resp_ready = 1;
      tick();
      q_resp_ready = 0;
   endtask

   initial begin
      clr_slave();
      test_reset();
      test_read();
      test_write();
      test_aw_delay();
      test_errors();
      test_back_to_back();
      test_resp_hold();
      test_reset_mid_burst();
      test_param_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
